branch_resolve_queue: RTL

//  Downstream companion of the bimodal predictor. Records every ID-stage branch prediction
//  (PC, taken bit, target) in a small in-order queue. Retires the oldest entry when the

---
 rtl/branch_resolve_queue_pkg.sv | 30 +++
 rtl/branch_resolve_queue_if.sv | 48 ++++
 rtl/branch_queue_fifo.sv | 62 ++++++
 rtl/branch_resolve_queue.sv | 116 +++++++++++
 4 files changed

// File: rtl/branch_resolve_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve_queue_pkg
// Brief   : Shared defaults, entry layout and helpers for the branch
//           resolve queue.
// Revision: 1.0 - initial release
// ============================================================================
package branch_resolve_queue_pkg;

    localparam int DEPTH_DEF      = 4;
    localparam int TABLE_BITS_DEF = 5;
    localparam int PC_W           = 32;
    localparam logic [PC_W-1:0] PC_INC = 32'd4;

    // One in-flight branch as recorded at ID.
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred_taken;
        logic [PC_W-1:0] pred_target;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_queue_if.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve_queue_if
// Brief   : ID push, MEM resolve and fetch/predictor feedback signals.
// Revision: 1.0 - initial release
// ============================================================================
interface branch_resolve_queue_if #(
    parameter int DEPTH      = 4,
    parameter int TABLE_BITS = 5
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic                  id_push;
    logic [31:0]           id_pc;
    logic                  id_pred_taken;
    logic [31:0]           id_pred_target;
    logic                  mem_pop;
    logic                  mem_taken;
    logic [31:0]           mem_target;
    logic                  ext_flush;
    logic                  mispredict;
    logic [31:0]           redirect_pc;
    logic                  upd_valid;
    logic [TABLE_BITS-1:0] upd_index;
    logic                  upd_taken;
    logic [OCC_W-1:0]      occupancy;
    logic                  overflow;
    logic                  underflow;
    logic [31:0]           branch_count;
    logic [31:0]           mispredict_count;

    // Pipeline side: drives branch events, observes feedback.
    modport master (
        output id_push, id_pc, id_pred_taken, id_pred_target,
               mem_pop, mem_taken, mem_target, ext_flush,
        input  mispredict, redirect_pc, upd_valid, upd_index, upd_taken,
               occupancy, overflow, underflow, branch_count, mispredict_count
    );

    // Queue side.
    modport slave (
        input  id_push, id_pc, id_pred_taken, id_pred_target,
               mem_pop, mem_taken, mem_target, ext_flush,
        output mispredict, redirect_pc, upd_valid, upd_index, upd_taken,
               occupancy, overflow, underflow, branch_count, mispredict_count
    );
endinterface
`default_nettype wire

// File: rtl/branch_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module  : branch_queue_fifo
// Brief   : In-order entry storage with wrap-around pointers and a separate
//           occupancy count. Enables are pre-qualified by the caller.
// Revision: 1.0 - initial release
// ============================================================================
module branch_queue_fifo
    import branch_resolve_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int OCC_W = $clog2(DEPTH) + 1
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_wr_en,
    input  wire entry_t           i_wr_data,
    input  wire logic             i_rd_en,
    input  wire logic             i_clr,
    output entry_t                o_head,
    output logic [OCC_W-1:0]      o_occupancy,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [OCC_W-1:0] c_FULL_OCC = OCC_W'(DEPTH);

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [OCC_W-1:0]   r_occ;

    assign o_head      = r_mem[r_rd_ptr];
    assign o_occupancy = r_occ;
    assign o_full      = (r_occ == c_FULL_OCC);
    assign o_empty     = (r_occ == '0);

    // Entry storage; contents are meaningless while not counted as live.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers and occupancy; clear empties the queue and wins over push/pop.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_wr_en, i_rd_en})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve_queue
// Brief   : Tracks ID-stage branch predictions, retires them at MEM, emits a
//           registered redirect and predictor update, keeps statistics.
// Revision: 1.0 - initial release
// ============================================================================
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int TABLE_BITS = TABLE_BITS_DEF
) (
    input  wire logic           clk,
    input  wire logic           reset,
    branch_resolve_queue_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    entry_t             w_head;
    entry_t             w_wr_data;
    logic [OCC_W-1:0]   w_occ;
    logic               w_full;
    logic               w_empty;
    logic               w_pop_valid;
    logic               w_mis;
    logic               w_clear;
    logic               w_push_ok;
    logic               w_overflow_evt;
    logic               w_underflow_evt;
    logic [31:0]        w_redirect;

    logic                  r_mispredict;
    logic [31:0]           r_redirect_pc;
    logic                  r_upd_valid;
    logic [TABLE_BITS-1:0] r_upd_index;
    logic                  r_upd_taken;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [31:0]           r_branch_count;
    logic [31:0]           r_mispredict_count;

    // Compare head prediction with the MEM outcome; decide queue actions.
    always_comb begin
        w_pop_valid = bus.mem_pop & ~w_empty;
        w_mis = w_pop_valid &
                ((w_head.pred_taken != bus.mem_taken) |
                 (w_head.pred_taken & bus.mem_taken &
                  (w_head.pred_target != bus.mem_target)));
        w_redirect = bus.mem_taken ? bus.mem_target : (w_head.pc + PC_INC);
        // A mispredict or external flush squashes everything, including a
        // same-cycle push, which is younger and therefore never overflows.
        w_clear         = bus.ext_flush | w_mis;
        w_push_ok       = bus.id_push & ~w_clear & (~w_full | w_pop_valid);
        w_overflow_evt  = bus.id_push & ~w_clear & w_full & ~w_pop_valid;
        w_underflow_evt = bus.mem_pop & w_empty;
        w_wr_data.pc          = bus.id_pc;
        w_wr_data.pred_taken  = bus.id_pred_taken;
        w_wr_data.pred_target = bus.id_pred_target;
    end

    branch_queue_fifo #(
        .DEPTH (DEPTH),
        .OCC_W (OCC_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_wr_en     (w_push_ok),
        .i_wr_data   (w_wr_data),
        .i_rd_en     (w_pop_valid),
        .i_clr       (w_clear),
        .o_head      (w_head),
        .o_occupancy (w_occ),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Register retirement results; data fields hold between pops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mispredict       <= 1'b0;
            r_redirect_pc      <= '0;
            r_upd_valid        <= 1'b0;
            r_upd_index        <= '0;
            r_upd_taken        <= 1'b0;
            r_overflow         <= 1'b0;
            r_underflow        <= 1'b0;
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            r_mispredict <= w_mis;
            r_upd_valid  <= w_pop_valid;
            if (w_pop_valid) begin
                r_redirect_pc  <= w_redirect;
                r_upd_index    <= w_head.pc[TABLE_BITS+1:2];
                r_upd_taken    <= bus.mem_taken;
                r_branch_count <= sat_inc(r_branch_count);
            end
            if (w_mis)           r_mispredict_count <= sat_inc(r_mispredict_count);
            if (w_overflow_evt)  r_overflow  <= 1'b1;
            if (w_underflow_evt) r_underflow <= 1'b1;
        end
    end

    assign bus.mispredict       = r_mispredict;
    assign bus.redirect_pc      = r_redirect_pc;
    assign bus.upd_valid        = r_upd_valid;
    assign bus.upd_index        = r_upd_index;
    assign bus.upd_taken        = r_upd_taken;
    assign bus.occupancy        = w_occ;
    assign bus.overflow         = r_overflow;
    assign bus.underflow        = r_underflow;
    assign bus.branch_count     = r_branch_count;
    assign bus.mispredict_count = r_mispredict_count;
endmodule
`default_nettype wire
